// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 row-scan controller.
package hub75_pkg;

    localparam int unsigned PIX_W  = 6;

    // Bit positions of each colour line within a pixel word {r1,g1,b1,r2,g2,b2}
    localparam int unsigned R1_BIT = 5;
    localparam int unsigned G1_BIT = 4;
    localparam int unsigned B1_BIT = 3;
    localparam int unsigned R2_BIT = 2;
    localparam int unsigned G2_BIT = 1;
    localparam int unsigned B2_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_DEAD,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hub75_col_shifter.sv
// Column shift sequencer: FETCH/LOAD/LOW/HIGH per pixel across one row pair.
// done is combinational and marks the final HIGH cycle of the last column.
module hub75_col_shifter
    import hub75_pkg::*;
#(
    parameter int unsigned COLS    = 64,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      done_c,
    output logic                      pix_rd,
    output logic [$clog2(COLS)-1:0]   pix_col,
    input  logic [PIX_W-1:0]          pix_data,
    output logic [PIX_W-1:0]          rgb,
    output logic                      sclk
);

    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned PH_W  = $clog2(CLK_DIV + 1);

    state_t            state;
    logic [PH_W-1:0]   phase;

    logic phase_last;
    logic col_last;

    assign phase_last = (phase == PH_W'(CLK_DIV - 1));
    assign col_last   = (pix_col == COL_W'(COLS - 1));
    assign done_c     = (state == ST_HIGH) && phase_last && col_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            phase   <= '0;
            pix_col <= '0;
            pix_rd  <= 1'b0;
            rgb     <= '0;
            sclk    <= 1'b0;
        end else begin
            pix_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        pix_col <= '0;
                        pix_rd  <= 1'b1;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    // Frame buffer answers one cycle after the read strobe
                    rgb   <= {pix_data[R1_BIT], pix_data[G1_BIT], pix_data[B1_BIT],
                              pix_data[R2_BIT], pix_data[G2_BIT], pix_data[B2_BIT]};
                    phase <= '0;
                    state <= ST_LOW;
                end
                ST_LOW: begin
                    if (phase_last) begin
                        phase <= '0;
                        sclk  <= 1'b1;
                        state <= ST_HIGH;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_last) begin
                        phase <= '0;
                        sclk  <= 1'b0;
                        if (col_last) begin
                            pix_col <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            pix_col <= pix_col + 1'b1;
                            pix_rd  <= 1'b1;
                            state   <= ST_FETCH;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 row-scan controller: shift, latch and display each row pair in turn.
// Define HUB75_DEADTIME_EN to insert DEAD_CYCLES of blanking before the row-address change.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned COLS        = 64,
    parameter int unsigned ROWS_HALF   = 16,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned LATCH_HOLD  = 300,
    parameter int unsigned ON_CYCLES   = 2000,
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    output logic                           pix_rd,
    output logic [$clog2(ROWS_HALF)-1:0]   pix_row,
    output logic [$clog2(COLS)-1:0]        pix_col,
    input  logic [PIX_W-1:0]               pix_data,
    output logic [PIX_W-1:0]               rgb,
    output logic                           sclk,
    output logic [$clog2(ROWS_HALF)-1:0]   row_addr,
    output logic                           oe_n,
    output logic                           latch_toggle,
    output logic                           frame_done
);

    localparam int unsigned ADDR_W  = $clog2(ROWS_HALF);
    localparam int unsigned CNT_MAX = max_u(max_u(LATCH_HOLD, ON_CYCLES), DEAD_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // ST_FETCH here stands for the whole shift phase owned by the column shifter
    state_t             state;
    logic [ADDR_W-1:0]  row;
    logic [CNT_W-1:0]   cnt;

    logic start_c;
    logic done_c;
    logic on_last;
    logic row_last;

    assign on_last  = (cnt == CNT_W'(ON_CYCLES - 1));
    assign row_last = (row == ADDR_W'(ROWS_HALF - 1));
    assign start_c  = enable && ((state == ST_IDLE) || ((state == ST_DISPLAY) && on_last));
    assign pix_row  = row;

    hub75_col_shifter #(
        .COLS    (COLS),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_c),
        .done_c   (done_c),
        .pix_rd   (pix_rd),
        .pix_col  (pix_col),
        .pix_data (pix_data),
        .rgb      (rgb),
        .sclk     (sclk)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            row          <= '0;
            cnt          <= '0;
            row_addr     <= '0;
            oe_n         <= 1'b1;
            latch_toggle <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (done_c) begin
                        cnt <= '0;
`ifdef HUB75_DEADTIME_EN
                        state <= ST_DEAD;
`else
                        state        <= ST_LATCH;
                        row_addr     <= row;
                        latch_toggle <= 1'b1;
`endif
                    end
                end
`ifdef HUB75_DEADTIME_EN
                ST_DEAD: begin
                    if (cnt == CNT_W'(DEAD_CYCLES - 1)) begin
                        cnt          <= '0;
                        state        <= ST_LATCH;
                        row_addr     <= row;
                        latch_toggle <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_LATCH: begin
                    // LAT request and output enable swap on the same edge
                    if (cnt == CNT_W'(LATCH_HOLD - 1)) begin
                        cnt          <= '0;
                        latch_toggle <= 1'b0;
                        oe_n         <= 1'b0;
                        state        <= ST_DISPLAY;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DISPLAY: begin
                    if (on_last) begin
                        cnt        <= '0;
                        oe_n       <= 1'b1;
                        frame_done <= row_last;
                        row        <= row_last ? '0 : row + 1'b1;
                        state      <= enable ? ST_FETCH : ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Row-scan controller for the HUB75 LED matrix panel, sitting directly upstream of the latch pulse generator. For each row pair, it reads pixels from the frame buffer and shifts them onto the panel's RGB and shift-clock lines. It then sets the row address and raises `latch_toggle`, which the pulse generator turns into the LAT strobe, and finally enables the display for a fixed on-time. It scans all row pairs continuously while `enable` is high.

## Interface
- `COLS`, 64, pixels per row.
- `ROWS_HALF`, 16, row pairs per frame; `ADDR_W = $clog2(ROWS_HALF)`.
- `CLK_DIV`, 4, clk cycles per shift-clock phase; must be ≥1.
- `LATCH_HOLD`, 300, clk cycles `latch_toggle` stays high; must exceed the pulse generator's setup + width (200 at its defaults).
- `ON_CYCLES`, 2000, clk cycles `oe_n` is low per row.
- `DEAD_CYCLES`, 8, blank cycles before the row address changes (used only with `HUB75_DEADTIME_EN`).

Ports:
- `clk` in 1: 100 MHz system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: run scanning.
- `pix_rd` out 1: frame-buffer read strobe.
- `pix_row` out ADDR_W: read row-pair address.
- `pix_col` out $clog2(COLS): read column.
- `pix_data` in 6: {r1,g1,b1,r2,g2,b2}; valid exactly 1 cycle after `pix_rd`.
- `rgb` out 6: panel data lines.
- `sclk` out 1: panel shift clock.
- `row_addr` out ADDR_W: panel A..D/E lines.
- `oe_n` out 1: panel output enable, active low.
- `latch_toggle` out 1: level request to the pulse generator.
- `frame_done` out 1: one-cycle pulse after the last row's on-time.

## Operation
- States and transitions:
  - IDLE → FETCH when `enable` = 1.
  - FETCH (`pix_rd` = 1, 1 cycle) → LOAD.
  - LOAD (`rgb` ← `pix_data`, 1 cycle) → LOW.
  - LOW (`sclk` = 0, CLK_DIV cycles) → HIGH.
  - HIGH (`sclk` = 1, CLK_DIV cycles) → FETCH with col + 1, or, after the last column, → DEAD (macro on) or LATCH.
  - DEAD (DEAD_CYCLES cycles) → LATCH.
  - LATCH (`row_addr` ← current row on entry, `latch_toggle` = 1 for LATCH_HOLD cycles) → DISPLAY.
  - DISPLAY (`oe_n` = 0, ON_CYCLES cycles) → next row FETCH, or IDLE if `enable` = 0.
- `oe_n` = 1 in every state except DISPLAY.
- Row counter wraps from ROWS_HALF-1 to 0. `frame_done` fires on the DISPLAY exit of row ROWS_HALF-1, even if scanning stops there.
- If `enable` drops mid-row, the current row completes through DISPLAY, then the block goes to IDLE. `enable` is sampled only at DISPLAY exit and in IDLE.
- Reset values: `rgb` = 0, `sclk` = 0, `row_addr` = 0, `oe_n` = 1, `latch_toggle` = 0, `pix_rd` = 0, `frame_done` = 0. State, row and column return to IDLE/0/0.
- A reset asserted mid-operation forces the reset values on the next edge; no partial row completes.
- Counters are unsigned and sized to the maximum of their parameters; they compare against (N-1) and clear on state exit.

## Timing
- Pixel period is 2 + 2·CLK_DIV cycles (10 at defaults).
- `rgb` is stable for the full LOW + HIGH phases, so it is valid CLK_DIV cycles before each `sclk` rise.
- Row period is COLS·(2+2·CLK_DIV) + LATCH_HOLD + ON_CYCLES, plus DEAD_CYCLES with the macro on.
- `latch_toggle` falls on the same edge that `oe_n` falls. The downstream generator returns to idle while `latch_toggle` stays low for ≥ ON_CYCLES.
- From `enable` rising in IDLE, the first `pix_rd` occurs on the next cycle.

## Configuration
- `HUB75_DEADTIME_EN` defined: DEAD state is inserted, giving DEAD_CYCLES of blanking before the row-address change (anti-ghosting).
- Not defined: HIGH goes directly to LATCH, and `row_addr` changes on the first LATCH cycle.

## Structure
- `hub75_pkg` holds:
  - the state enum;
  - the `PIX_W` = 6 constant;
  - the RGB bit-index constants.
- One natural sub-module, `hub75_col_shifter`, contains the FETCH/LOAD/LOW/HIGH sequencer and the column counter, with a start/done handshake to the top FSM.

## Test plan
Bench parameters: COLS = 4, ROWS_HALF = 2, CLK_DIV = 2, LATCH_HOLD = 10, ON_CYCLES = 20.
- Reset then `enable` = 1 → `pix_rd` pulses at cycles 1, 7, 13, 19 with `pix_col` = 0..3. The `rgb` values driven by the bench appear on 4 `sclk` rises.
- Full frame, macro off → row period = 54 cycles; `row_addr` is 0 then 1; `frame_done` pulses once at cycle 108, then the scan wraps to row 0.
- `HUB75_DEADTIME_EN` with DEAD_CYCLES = 8 → row period = 62 cycles; `row_addr` changes 8 cycles after the last `sclk` fall.
- `enable` dropped during row 0 shift → row 0 latches and displays for 20 cycles, then IDLE with `oe_n` = 1; no further `pix_rd`.
- `rst_n` low during LATCH → next edge has `latch_toggle` = 0, `oe_n` = 1, `row_addr` = 0, `sclk` = 0.
- Latch/blank overlap check → `oe_n` = 1 for every cycle `latch_toggle` = 1 or `sclk` toggles.
